seq_squarer: RTL and testbench
==============================

// Module: seq_squarer
// PURPOSE
//   Multi-cycle shift-add squarer: accepts a DATA_WIDTH-bit unsigned operand, returns its
//   2*DATA_WIDTH-bit square. Inverse of square_root; squares sqrt results in the baggage-drop
//   height path for self-check, and serves as a reusable arithmetic block behind a handshake.
// PARAMETERS
//   DATA_WIDTH  8  operand width in bits (>=2); result is 2*DATA_WIDTH bits
// PORTS
//   clk        in   1             single clock, rising edge
//   rst        in   1             asynchronous, active-high reset
//   in_valid   in   1             operand present on in
//   in_ready   out  1             block can accept an operand
//   in         in   DATA_WIDTH    unsigned operand
//   out_valid  out  1             result present on out
//   out_ready  in   1             consumer accepts the result
//   out        out  2*DATA_WIDTH  in*in, unsigned, exact
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): state=IDLE, in_ready=1, out_valid=0, out=0,
//     internal acc/operand/counter=0. Reset mid-operation aborts; no result is emitted.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: in_ready=1. Edge with in_valid&in_ready: capture A=zero-extend(in) to 2*DATA_WIDTH,
//     B=in, acc=0, cnt=0; go BUSY. in_ready drops the cycle after acceptance.
//   - BUSY: in_ready=0, out_valid=0. Each edge: if B[0] acc<=acc+A; A<=A<<1; B<=B>>1; cnt<=cnt+1.
//     After DATA_WIDTH BUSY edges (cnt==DATA_WIDTH-1 on last) go DONE. No early exit:
//     latency is fixed for all operands.
//   - Latency: operand accepted at edge t0 -> out_valid high after edge t0+DATA_WIDTH
//     (8 cycles at default).
//   - DONE: out_valid=1, out=acc, in_ready=0. out and out_valid held stable while out_ready=0
//     (unbounded backpressure). Edge with out_valid&out_ready: out_valid<=0, go IDLE.
//     out keeps last result (not cleared) until next DONE.
//   - No same-cycle output-retire + input-accept; min issue interval = DATA_WIDTH+2 cycles
//     with out_ready tied high.
//   - in_valid while in_ready=0 is ignored; in need not be held after acceptance.
//   - Accumulator is 2*DATA_WIDTH bits; max (2^N-1)^2 fits, no overflow/saturation logic.
//   - cnt width = clog2(DATA_WIDTH)+1 to avoid wrap at DATA_WIDTH a power of two.
//   - X on in when in_valid=0 must not propagate to out.
// STRUCTURE
//   - Shared baggage-drop header/package: DATA_WIDTH default (matches square_root), FSM state
//     encodings (SQ_IDLE, SQ_BUSY, SQ_DONE), 2-bit state width.
//   - Flat module: one FSM always block + datapath registers; no sub-module. Shift-add step
//     is inline; a separate step module is not warranted.
// TESTING
//   - Compare against combinational reference in*in in the standard ref/tst tester harness.
//   1 reset, in=0 valid 1 cycle, out_ready=1 -> out_valid after 8 cycles, out=16'd0
//   2 in=8'd255 -> out=16'd65025 (0xFE01); in=8'd16 -> 16'd256; in=8'd1 -> 16'd1
//   3 in=8'd200, out_ready=0 for 20 cycles -> out_valid,out=16'd40000 stable, in_ready=0;
//     raise out_ready -> out_valid low next edge, in_ready high
//   4 in=8'd100 accepted, assert rst at cycle 4 of BUSY -> out_valid=0, out=0, in_ready=1
//     immediately (async); next in=8'd3 -> 16'd9 with normal latency
//   5 in_valid held high with changing in (10,20,30) while busy -> only 10 captured;
//     out=16'd100; 20 accepted only after retire
//   6 exhaustive sweep 0..255, random out_ready backpressure -> all match in*in, no drops
//     or duplicates

Source files
------------

// File: rtl/seq_squarer_pkg.sv
// seq_squarer_pkg: shared width default and FSM encodings for the shift-add squarer
package seq_squarer_pkg;
    localparam int SQ_DATA_WIDTH = 8;
    localparam int SQ_STATE_W = 2;
    localparam logic [SQ_STATE_W-1:0] SQ_IDLE = 2'd0;
    localparam logic [SQ_STATE_W-1:0] SQ_BUSY = 2'd1;
    localparam logic [SQ_STATE_W-1:0] SQ_DONE = 2'd2;
endpackage

// File: rtl/seq_squarer.sv
// seq_squarer: fixed-latency shift-add squarer behind a valid/ready handshake
module seq_squarer
    import seq_squarer_pkg::*;
#(
    parameter int DATA_WIDTH = SQ_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    logic [SQ_STATE_W-1:0]   r_state;
    logic [2*DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]           r_cnt;
    logic [2*DATA_WIDTH-1:0] r_out;
    logic [2*DATA_WIDTH-1:0] w_acc_nxt;
    logic                    w_last;

    assign in_ready  = r_state == SQ_IDLE;
    assign out_valid = r_state == SQ_DONE;
    assign out       = r_out;
    assign w_acc_nxt = r_b[0] ? r_acc + r_a : r_acc;
    assign w_last    = r_cnt == CW'(DATA_WIDTH - 1);

    // r_out is separate from r_acc so the last result survives the next acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SQ_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else if (r_state == SQ_IDLE) begin
            if (in_valid) begin
                r_a     <= {{DATA_WIDTH{1'b0}}, in};
                r_b     <= in;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= SQ_BUSY;
            end
        end else if (r_state == SQ_BUSY) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_out   <= w_acc_nxt;
                r_state <= SQ_DONE;
            end
        end else if (r_state == SQ_DONE) begin
            if (out_ready) r_state <= SQ_IDLE;
        end else begin
            r_state <= SQ_IDLE;
        end
    end
endmodule

// File: tb/tb_seq_squarer.sv
// tb_seq_squarer: directed vectors plus a full operand sweep under random backpressure
module tb_seq_squarer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    int          total = 0;
    int          bad = 0;
    int          n;

    always #5 clk = ~clk;

    seq_squarer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 8);
    endtask

    task automatic xact(input logic [7:0] v, input bit bp, input string tag);
        int k;
        @(negedge clk);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 1);
        in = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in = 'x;
        wait_done(tag);
        chk({tag, "_out"}, {16'd0, out}, 32'(v) * 32'(v));
        k = 0;
        while (out_valid && k < 200) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid) chk({tag, "_hold"}, {16'd0, out}, 32'(v) * 32'(v));
            k++;
        end
        chk({tag, "_retire"}, {31'd0, out_valid}, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out", {16'd0, out}, 0);
        rst = 1'b0;

        xact(8'd0, 1'b0, "sq0");
        xact(8'd255, 1'b0, "sq255");
        xact(8'd16, 1'b0, "sq16");
        xact(8'd1, 1'b0, "sq1");

        // long backpressure: result and flags must sit still
        @(negedge clk);
        in = 8'd200;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("bp");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_out", {16'd0, out}, 40000);
            chk("bp_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_retire_valid", {31'd0, out_valid}, 0);
        chk("bp_retire_ready", {31'd0, in_ready}, 1);
        chk("bp_out_kept", {16'd0, out}, 40000);
        out_ready = 1'b0;

        // asynchronous abort mid-computation
        @(negedge clk);
        in = 8'd100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 0);
        chk("abort_out", {16'd0, out}, 0);
        chk("abort_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        xact(8'd3, 1'b0, "after_abort");

        // in_valid held high while busy: only the first operand is taken
        @(negedge clk);
        in = 8'd10;
        in_valid = 1'b1;
        @(negedge clk);
        in = 8'd20;
        @(negedge clk);
        in = 8'd30;
        @(negedge clk);
        in = 8'd20;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out", {16'd0, out}, 100);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_retire_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b0;
        @(negedge clk);
        chk("hold_second_taken", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        wait_done("hold2");
        chk("hold2_out", {16'd0, out}, 400);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        for (int v = 0; v < 256; v++) xact(8'(v), 1'b1, "sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
